udp_tx_pkt_src: RTL and testbench

Packetising source for the UDP transmit path, in the `gmii_tx_clk` domain. It accepts a byte stream (camera/test payload), packs bytes big-endian into 32-bit words and stores them in an internal word FIFO. When enough data is buffered, or on a flush, it launches a UDP packet through the `tx_start_en` / `tx_byte_num` / `tx_req` / `tx_data` / `tx_done` interface of the UDP engine. It enforces an inter-packet gap between packets.

---
 rtl/udp_tx_pkt_src.sv | 103 ++++++++++
 tb/tb_udp_tx_pkt_src.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/udp_tx_pkt_src.sv
// udp_tx_pkt_src: packs a byte stream into 32-bit words and launches UDP payload packets
// Ports: din_vld_i/din_i/din_last_i/din_rdy_o byte input (din_last_i requests a flush);
//        tx_start_en_o/tx_byte_num_o/tx_data_o/tx_req_i/tx_done_i UDP engine handshake;
//        busy_o while a packet or gap is in progress; underflow_o sticky on a word request with an empty FIFO.
module udp_tx_pkt_src #(
  parameter int PKT_BYTES  = 1024,
  parameter int FIFO_AW    = 10,
  parameter int GAP_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        din_vld_i,
  input  logic [7:0]  din_i,
  input  logic        din_last_i,
  output logic        din_rdy_o,
  output logic        tx_start_en_o,
  output logic [15:0] tx_byte_num_o,
  output logic [31:0] tx_data_o,
  input  logic        tx_req_i,
  input  logic        tx_done_i,
  output logic        busy_o,
  output logic        underflow_o
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int GW = $clog2(GAP_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, START, SEND, GAP} state_t;
  state_t             state_q;
  logic [31:0]        mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   words_q, words_d;
  logic [15:0]        bytes_q, bytes_d, len;
  logic [31:0]        pack_q, push_word;
  logic [1:0]         pack_cnt_q;
  logic [2:0]         push_bytes;
  logic [GW-1:0]      gap_cnt_q;
  logic               flush_q, accept, push, pop, under, go;
  assign din_rdy_o  = (words_q < (FIFO_AW+1)'(DEPTH - 1)) && !flush_q;
  assign accept     = din_vld_i && din_rdy_o;
  assign push       = accept && (pack_cnt_q == 2'd3 || din_last_i);
  assign push_bytes = push ? {1'b0, pack_cnt_q} + 3'd1 : 3'd0;
  // New byte lands MSB-first; unfilled low bytes of pack_q are always zero, giving the padding.
  assign push_word  = pack_q | ({din_i, 24'd0} >> {pack_cnt_q, 3'b000});
  assign go         = state_q == IDLE && (bytes_q >= 16'(PKT_BYTES) || (flush_q && bytes_q != '0));
  assign len        = bytes_q >= 16'(PKT_BYTES) ? 16'(PKT_BYTES) : bytes_q;
  assign pop        = state_q == SEND && tx_req_i && words_q != '0;
  assign under      = state_q == SEND && tx_req_i && words_q == '0;
  // Byte count nets the pushed bytes against the length committed to a starting packet.
  assign bytes_d    = bytes_q + 16'(push_bytes) - (go ? len : 16'd0);
  assign words_d    = words_q + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
  assign busy_o     = state_q != IDLE;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr_q] <= push_word;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      words_q       <= '0;
      bytes_q       <= '0;
      pack_q        <= '0;
      pack_cnt_q    <= '0;
      gap_cnt_q     <= '0;
      flush_q       <= 1'b0;
      tx_start_en_o <= 1'b0;
      tx_byte_num_o <= '0;
      tx_data_o     <= '0;
      underflow_o   <= 1'b0;
    end else begin
      words_q     <= words_d;
      bytes_q     <= bytes_d;
      wr_ptr_q    <= wr_ptr_q + FIFO_AW'(push);
      rd_ptr_q    <= rd_ptr_q + FIFO_AW'(pop);
      underflow_o <= underflow_o | under;
      if (accept) begin
        pack_q     <= push ? '0 : push_word;
        pack_cnt_q <= push ? 2'd0 : pack_cnt_q + 2'd1;
      end
      if (pop) tx_data_o <= mem[rd_ptr_q];
      else if (under) tx_data_o <= '0;
      // A flush stays pending until IDLE finds nothing left to send.
      if (accept && din_last_i) flush_q <= 1'b1;
      else if (state_q == IDLE && !go && bytes_q == '0) flush_q <= 1'b0;
      case (state_q)
        IDLE: if (go) begin
          state_q       <= START;
          tx_byte_num_o <= len;
          tx_start_en_o <= 1'b1;
        end
        START: begin
          state_q       <= SEND;
          tx_start_en_o <= 1'b0;
        end
        SEND: if (tx_done_i) begin
          state_q   <= GAP;
          gap_cnt_q <= '0;
        end
        default: begin
          state_q   <= gap_cnt_q == GW'(GAP_CYCLES - 1) ? IDLE : GAP;
          gap_cnt_q <= gap_cnt_q + GW'(1);
        end
      endcase
    end
endmodule

// File: tb/tb_udp_tx_pkt_src.sv
// tb_udp_tx_pkt_src: directed and randomized bench for udp_tx_pkt_src against a byte-queue model
module tb_udp_tx_pkt_src;
  localparam int PKT = 16, AW = 3, GAP = 4;
  logic clk = 1'b0, rst_n = 1'b0, din_vld = 1'b0, din_last = 1'b0, tx_req = 1'b0, tx_done = 1'b0;
  logic [7:0]  din = '0;
  logic        din_rdy, tx_start_en, busy, underflow;
  logic [15:0] tx_byte_num;
  logic [31:0] tx_data;
  int cyc = 0, total = 0, passed = 0, done_cyc = -1;
  logic [7:0] mq [$];
  udp_tx_pkt_src #(.PKT_BYTES(PKT), .FIFO_AW(AW), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .din_vld_i(din_vld), .din_i(din), .din_last_i(din_last),
    .din_rdy_o(din_rdy), .tx_start_en_o(tx_start_en), .tx_byte_num_o(tx_byte_num),
    .tx_data_o(tx_data), .tx_req_i(tx_req), .tx_done_i(tx_done), .busy_o(busy),
    .underflow_o(underflow)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic feed(input int n, input bit last, input bit rnd, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      int k;
      k = 0;
      din      = rnd ? 8'($urandom) : base + 8'(i);
      din_last = last && (i == n - 1);
      din_vld  = 1'b1;
      while (!din_rdy && k < 400) begin
        tick();
        k++;
      end
      chk("rdy_wait", 32'(din_rdy), 32'(1));
      mq.push_back(din);
      tick();
      din_vld  = 1'b0;
      din_last = 1'b0;
      if ($urandom_range(0, 3) == 0) tick();
    end
  endtask
  task automatic next_word(input int nb, output logic [31:0] w);
    w = '0;
    for (int j = 0; j < nb; j++) w |= 32'(mq.pop_front()) << (24 - 8 * j);
  endtask
  task automatic wait_start(input int len);
    int k;
    k = 0;
    while (tx_start_en !== 1'b1 && k < 3000) begin
      tick();
      k++;
    end
    chk("start_seen", 32'(tx_start_en), 32'(1));
    chk("byte_num", 32'(tx_byte_num), 32'(len));
    if (done_cyc >= 0) chk("gap", 32'(cyc - done_cyc >= GAP + 2), 32'(1));
    tick();
    chk("start_pulse", 32'(tx_start_en), 32'(0));
    chk("num_hold", 32'(tx_byte_num), 32'(len));
  endtask
  task automatic recv_words(input int len);
    for (int r = len; r > 0; r -= 4) begin
      logic [31:0] w;
      next_word(r > 4 ? 4 : r, w);
      tx_req = 1'b1;
      tick();
      tx_req = 1'b0;
      chk("tx_data", tx_data, w);
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask
  task automatic send_done();
    tx_done  = 1'b1;
    done_cyc = cyc;
    tick();
    tx_done  = 1'b0;
    chk("busy_gap", 32'(busy), 32'(1));
  endtask
  task automatic recv_pkt(input int len);
    wait_start(len);
    recv_words(len);
    send_done();
  endtask
  task automatic recv_flush(input int n);
    for (int p = 0; p < n / PKT; p++) recv_pkt(PKT);
    if (n % PKT != 0) recv_pkt(n % PKT);
  endtask
  task automatic wait_ready();
    int k;
    k = 0;
    while ((busy || !din_rdy) && k < 100) begin
      tick();
      k++;
    end
    chk("idle_busy", 32'(busy), 32'(0));
    chk("idle_rdy", 32'(din_rdy), 32'(1));
  endtask
  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rdy"}, 32'(din_rdy), 32'(1));
    chk({tag, "_start"}, 32'(tx_start_en), 32'(0));
    chk({tag, "_num"}, 32'(tx_byte_num), 32'(0));
    chk({tag, "_data"}, tx_data, 32'(0));
    chk({tag, "_busy"}, 32'(busy), 32'(0));
    chk({tag, "_uf"}, 32'(underflow), 32'(0));
  endtask
  initial begin
    logic [31:0] w;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check_reset_outputs("reset");
    tick();
    fork
      feed(16, 1'b0, 1'b0, 8'h00);
      begin
        wait_start(16);
        recv_words(16);
        send_done();
        tx_req = 1'b1;
        tick();
        tx_req = 1'b0;
        chk("hold_data", tx_data, 32'h0C0D0E0F);
        chk("no_uf_gap", 32'(underflow), 32'(0));
      end
    join
    wait_ready();
    fork
      feed(6, 1'b1, 1'b0, 8'hA1);
      begin
        wait_start(6);
        chk("rdy_send", 32'(din_rdy), 32'(0));
        recv_words(6);
        send_done();
        chk("rdy_gap", 32'(din_rdy), 32'(0));
      end
    join
    wait_ready();
    fork
      feed(40, 1'b1, 1'b1, 8'h00);
      recv_flush(40);
    join
    wait_ready();
    fork
      feed(28, 1'b0, 1'b1, 8'h00);
      wait_start(16);
    join
    chk("bp_full", 32'(din_rdy), 32'(0));
    repeat (3) tick();
    chk("bp_hold", 32'(din_rdy), 32'(0));
    next_word(4, w);
    tx_req = 1'b1;
    chk("bp_pre_pop", 32'(din_rdy), 32'(0));
    tick();
    tx_req = 1'b0;
    chk("bp_data", tx_data, w);
    chk("bp_recover", 32'(din_rdy), 32'(1));
    recv_words(12);
    send_done();
    fork
      feed(4, 1'b0, 1'b1, 8'h00);
      recv_pkt(16);
    join
    wait_ready();
    for (int it = 0; it < 3; it++) begin
      int n;
      n = $urandom_range(1, 40);
      fork
        feed(n, 1'b1, 1'b1, 8'h00);
        recv_flush(n);
      join
      wait_ready();
    end
    fork
      feed(6, 1'b1, 1'b1, 8'h00);
      begin
        wait_start(6);
        recv_words(6);
      end
    join
    chk("uf_before", 32'(underflow), 32'(0));
    tx_req = 1'b1;
    tick();
    tx_req = 1'b0;
    chk("uf_set", 32'(underflow), 32'(1));
    chk("uf_data", tx_data, 32'(0));
    send_done();
    wait_ready();
    chk("uf_sticky", 32'(underflow), 32'(1));
    fork
      feed(16, 1'b0, 1'b1, 8'h00);
      begin
        wait_start(16);
        recv_words(8);
      end
    join
    #3 rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    mq.delete();
    done_cyc = -1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    fork
      feed(16, 1'b0, 1'b1, 8'h00);
      recv_pkt(16);
    join
    wait_ready();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
